// File: rtl/i2c_target_ctrl.sv
// ----------------------------------------------------------------------------
// i2c_target_ctrl
// Control FSM of an I2C target. It consumes synchronised SCL edge pulses,
// the SDA level, sticky START/STOP flags and the received shift byte. It
// produces the shift enable, the read bit index, the register pointer, a
// write strobe and the SDA drive requests (ACK / data).
//
// Parameters
//   BASE_ADDR  7-bit address base; effective address = BASE_ADDR + i_addr_sel
//   REGCOUNT   number of registers (2..32); register 0 is read-only
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   i_scl_posedge  in   1-cycle pulse on SCL rising edge
//   i_scl_negedge  in   1-cycle pulse on SCL falling edge
//   i_sda          in   synchronised SDA level
//   i_start_flag   in   sticky START seen, held until o_clear_start
//   i_stop_flag    in   sticky STOP seen, held until o_clear_stop
//   i_rx_byte      in   shift register contents, MSB first
//   i_addr_sel     in   address offset select
//   o_clear_start  out  1-cycle pulse clearing the START flag
//   o_clear_stop   out  1-cycle pulse clearing the STOP flag
//   o_shift_en     out  shift register samples SDA on SCL rise while high
//   o_bit_idx      out  bit of the current read byte to drive (0 = MSB)
//   o_reg_ptr      out  current register pointer
//   o_we           out  1-cycle write strobe of i_rx_byte to o_reg_ptr
//   o_send_ack     out  pull SDA low for ACK
//   o_out_en       out  drive SDA from the addressed register bit
//   o_busy         out  FSM not idle
// ----------------------------------------------------------------------------
module i2c_target_ctrl #(
    parameter logic [6:0] BASE_ADDR = 7'h20,
    parameter int         REGCOUNT  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_scl_posedge,
    input  logic       i_scl_negedge,
    input  logic       i_sda,
    input  logic       i_start_flag,
    input  logic       i_stop_flag,
    input  logic [7:0] i_rx_byte,
    input  logic [1:0] i_addr_sel,
    output logic       o_clear_start,
    output logic       o_clear_stop,
    output logic       o_shift_en,
    output logic [2:0] o_bit_idx,
    output logic [4:0] o_reg_ptr,
    output logic       o_we,
    output logic       o_send_ack,
    output logic       o_out_en,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_RACK
    } state_t;

    localparam logic [5:0] REG_LIMIT = 6'(REGCOUNT);
    localparam logic [4:0] LAST_REG  = 5'(REGCOUNT - 1);

    state_t     r_state,       w_state_nxt;
    logic [3:0] r_cnt,         w_cnt_nxt;
    logic [4:0] r_reg_ptr,     w_reg_ptr_nxt;
    logic       r_rw,          w_rw_nxt;
    logic       r_mack,        w_mack_nxt;
    logic       r_clear_start, w_clear_start_nxt;
    logic       r_clear_stop,  w_clear_stop_nxt;
    logic       r_we,          w_we_nxt;

    logic [6:0] w_target;
    logic [4:0] w_ptr_inc;
    logic       w_rx_state;
    logic       w_byte_done;
    logic       w_start;
    logic       w_stop;

    assign w_target    = BASE_ADDR + {5'b0, i_addr_sel};
    assign w_ptr_inc   = (r_reg_ptr == LAST_REG) ? 5'd0 : r_reg_ptr + 5'd1;
    assign w_rx_state  = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_WRITE);
    assign w_byte_done = r_cnt[3] && i_scl_negedge;

    // A flag is still set during the cycle its clear pulse is out; masking it
    // there keeps one pulse per event and lets a START that arrived together
    // with a STOP be taken on the very next cycle.
    assign w_start = i_start_flag && !r_clear_start;
    assign w_stop  = i_stop_flag  && !r_clear_stop;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_reg_ptr_nxt     = r_reg_ptr;
        w_rw_nxt          = r_rw;
        w_mack_nxt        = r_mack;
        w_clear_start_nxt = 1'b0;
        w_clear_stop_nxt  = 1'b0;
        w_we_nxt          = 1'b0;

        // Receive bit counter saturates at 8 until the byte is consumed.
        if (w_rx_state && i_scl_posedge && !r_cnt[3]) begin
            w_cnt_nxt = r_cnt + 4'd1;
        end

        if (w_stop) begin
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = 4'd0;
            w_clear_stop_nxt = 1'b1;
        end else if (w_start) begin
            // Covers both a fresh START from IDLE and a repeated START; a
            // partially received byte is simply dropped.
            w_state_nxt       = S_ADDR;
            w_cnt_nxt         = 4'd0;
            w_clear_start_nxt = 1'b1;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_byte_done) begin
                        if (i_rx_byte[7:1] == w_target) begin
                            w_state_nxt = S_ADDR_ACK;
                            w_rw_nxt    = i_rx_byte[0];
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (i_scl_negedge) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = r_rw ? S_READ : S_PTR;
                    end
                end
                S_PTR: begin
                    if (w_byte_done) begin
                        w_state_nxt   = S_PTR_ACK;
                        w_reg_ptr_nxt = ({1'b0, i_rx_byte[4:0]} < REG_LIMIT) ? i_rx_byte[4:0] : 5'd0;
                    end
                end
                S_PTR_ACK: begin
                    if (i_scl_negedge) begin
                        w_state_nxt = S_WRITE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_WRITE: begin
                    if (w_byte_done) begin
                        w_state_nxt = S_WRITE_ACK;
                        // Register 0 is read-only: the byte is ACKed but not written.
                        w_we_nxt    = (r_reg_ptr != 5'd0);
                    end
                end
                S_WRITE_ACK: begin
                    if (i_scl_negedge) begin
                        w_state_nxt   = S_WRITE;
                        w_cnt_nxt     = 4'd0;
                        w_reg_ptr_nxt = w_ptr_inc;
                    end
                end
                S_READ: begin
                    if (i_scl_negedge) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_state_nxt = S_RACK;
                        end
                    end
                end
                S_RACK: begin
                    if (i_scl_posedge) begin
                        w_mack_nxt = !i_sda;
                    end
                    if (i_scl_negedge) begin
                        w_reg_ptr_nxt = w_ptr_inc;
                        if (r_mack) begin
                            w_state_nxt = S_READ;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_reg_ptr     <= 5'd0;
            r_rw          <= 1'b0;
            r_mack        <= 1'b0;
            r_clear_start <= 1'b0;
            r_clear_stop  <= 1'b0;
            r_we          <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_reg_ptr     <= w_reg_ptr_nxt;
            r_rw          <= w_rw_nxt;
            r_mack        <= w_mack_nxt;
            r_clear_start <= w_clear_start_nxt;
            r_clear_stop  <= w_clear_stop_nxt;
            r_we          <= w_we_nxt;
        end
    end

    // SDA drive requests decode straight from state so a reset releases the
    // bus immediately; ACK states and READ are disjoint.
    assign o_shift_en    = w_rx_state && !r_cnt[3];
    assign o_bit_idx     = r_cnt[2:0];
    assign o_reg_ptr     = r_reg_ptr;
    assign o_we          = r_we;
    assign o_clear_start = r_clear_start;
    assign o_clear_stop  = r_clear_stop;
    assign o_send_ack    = (r_state == S_ADDR_ACK) || (r_state == S_PTR_ACK) || (r_state == S_WRITE_ACK);
    assign o_out_en      = (r_state == S_READ);
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_ctrl
// Drives I2C transactions at the bit level (edge pulses, flags, shift byte)
// and checks the controller against a transaction-level reference model.
// Expected per-SCL-clock observations, writes and flag-clear events are
// queued by the stimulus and consumed by an independent monitor.
// ----------------------------------------------------------------------------
module tb_i2c_target_ctrl;

    localparam int RC   = 8;
    localparam int BASE = 'h20;

    typedef struct packed {
        logic       ack;
        logic       oe;
        logic [2:0] bidx;
        logic [4:0] ptr;
        logic       busy;
    } slot_t;

    typedef struct packed {
        logic [4:0] ptr;
        logic [7:0] data;
    } wr_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl_pos = 1'b0;
    logic       scl_neg = 1'b0;
    logic       sda_m = 1'b1;
    logic       start_flag = 1'b0;
    logic       stop_flag = 1'b0;
    logic       start_req = 1'b0;
    logic       stop_req = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    logic [1:0] addr_sel = 2'd0;

    logic       o_clear_start, o_clear_stop, o_shift_en, o_we;
    logic       o_send_ack, o_out_en, o_busy;
    logic [2:0] o_bit_idx;
    logic [4:0] o_reg_ptr;
    logic       sda_bus;

    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;

    slot_t      exp_slot[$];
    wr_t        exp_wr[$];
    logic [4:0] exp_stop[$];
    logic [4:0] exp_start[$];

    i2c_target_ctrl #(.BASE_ADDR(7'h20), .REGCOUNT(RC)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_scl_posedge (scl_pos),
        .i_scl_negedge (scl_neg),
        .i_sda         (sda_bus),
        .i_start_flag  (start_flag),
        .i_stop_flag   (stop_flag),
        .i_rx_byte     (rx_sh),
        .i_addr_sel    (addr_sel),
        .o_clear_start (o_clear_start),
        .o_clear_stop  (o_clear_stop),
        .o_shift_en    (o_shift_en),
        .o_bit_idx     (o_bit_idx),
        .o_reg_ptr     (o_reg_ptr),
        .o_we          (o_we),
        .o_send_ack    (o_send_ack),
        .o_out_en      (o_out_en),
        .o_busy        (o_busy)
    );

    always #5 clock = ~clock;

    // Wired-AND bus: the master releases (1) or pulls low; the target pulls for ACK.
    assign sda_bus = sda_m & ~o_send_ack;

    // Sticky flags and the external shift register.
    always @(posedge clock) begin
        if (start_req)          start_flag <= 1'b1;
        else if (o_clear_start) start_flag <= 1'b0;
        if (stop_req)           stop_flag <= 1'b1;
        else if (o_clear_stop)  stop_flag <= 1'b0;
        if (scl_pos && o_shift_en) rx_sh <= {rx_sh[6:0], sda_bus};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents an event.
    always @(negedge clock) begin : monitor
        slot_t      es;
        wr_t        ew;
        logic [4:0] ep;
        if (!reset) begin
            if (scl_pos) begin
                if (exp_slot.size() == 0) begin
                    check("slot unexpected", 32'd1, 32'd0);
                end else begin
                    es = exp_slot.pop_front();
                    check("slot {ack,oe,bit,ptr,busy}",
                          32'({o_send_ack, o_out_en, (es.oe ? o_bit_idx : 3'd0), o_reg_ptr, o_busy}),
                          32'(es));
                end
            end
            if (o_we) begin
                if (exp_wr.size() == 0) begin
                    check("write unexpected", {19'd0, o_reg_ptr, rx_sh}, 32'hFFFF_FFFF);
                end else begin
                    ew = exp_wr.pop_front();
                    check("write {ptr,data}", {19'd0, o_reg_ptr, rx_sh}, 32'(ew));
                end
            end
            if (o_clear_stop) begin
                if (exp_stop.size() == 0) begin
                    check("clear_stop unexpected", 32'd1, 32'd0);
                end else begin
                    ep = exp_stop.pop_front();
                    check("stop {busy,we,ptr}", 32'({o_busy, o_we, o_reg_ptr}), 32'({1'b0, 1'b0, ep}));
                end
            end
            if (o_clear_start) begin
                if (exp_start.size() == 0) begin
                    check("clear_start unexpected", 32'd1, 32'd0);
                end else begin
                    ep = exp_start.pop_front();
                    check("start {busy,ptr}", 32'({o_busy, o_reg_ptr}), 32'({1'b1, ep}));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One SCL clock with the master driving bit b; e is what the target
    // should present while SCL rises.
    task automatic clk_bit(input logic b, input slot_t e);
        exp_slot.push_back(e);
        tick(2);
        sda_m = b;
        tick(2);
        scl_pos = 1'b1;
        tick(1);
        scl_pos = 1'b0;
        tick(2);
        scl_neg = 1'b1;
        tick(1);
        scl_neg = 1'b0;
        tick(1);
    endtask

    function automatic slot_t mk(input logic ack, input logic oe, input int bidx, input int ptr, input logic busy);
        slot_t s;
        s.ack  = ack;
        s.oe   = oe;
        s.bidx = 3'(bidx);
        s.ptr  = 5'(ptr);
        s.busy = busy;
        return s;
    endfunction

    task automatic send_start();
        exp_start.push_back(5'(m_ptr));
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
        tick(4);
    endtask

    task automatic send_stop();
        exp_stop.push_back(5'(m_ptr));
        stop_req = 1'b1;
        tick(1);
        stop_req = 1'b0;
        tick(4);
    endtask

    // START and STOP landing together: STOP first, START one cycle later.
    task automatic send_stop_start();
        exp_stop.push_back(5'(m_ptr));
        exp_start.push_back(5'(m_ptr));
        stop_req  = 1'b1;
        start_req = 1'b1;
        tick(1);
        stop_req  = 1'b0;
        start_req = 1'b0;
        tick(4);
    endtask

    task automatic master_byte(input logic [7:0] b, input logic busy_bits, input logic ack,
                               input int ptr_bits, input int ptr_ack, input logic busy_ack);
        for (int i = 7; i >= 0; i--) clk_bit(b[i], mk(1'b0, 1'b0, 0, ptr_bits, busy_bits));
        clk_bit(1'b1, mk(ack, 1'b0, 0, ptr_ack, busy_ack));
    endtask

    task automatic do_addr(input logic [7:0] a, output logic hit);
        hit = (int'(a[7:1]) == BASE + int'(addr_sel));
        master_byte(a, 1'b1, hit, m_ptr, m_ptr, hit);
    endtask

    task automatic do_ptr(input logic [7:0] b);
        int p;
        p = int'(b[4:0]) < RC ? int'(b[4:0]) : 0;
        master_byte(b, 1'b1, 1'b1, m_ptr, p, 1'b1);
        m_ptr = p;
    endtask

    task automatic do_wdata(input logic [7:0] b);
        if (m_ptr != 0) exp_wr.push_back({5'(m_ptr), b});
        master_byte(b, 1'b1, 1'b1, m_ptr, m_ptr, 1'b1);
        m_ptr = (m_ptr + 1) % RC;
    endtask

    task automatic do_rbyte(input logic mack);
        for (int i = 0; i < 8; i++) clk_bit(1'b1, mk(1'b0, 1'b1, i, m_ptr, 1'b1));
        clk_bit(!mack, mk(1'b0, 1'b0, 0, m_ptr, 1'b1));
        m_ptr = (m_ptr + 1) % RC;
    endtask

    task automatic idle_byte(input logic [7:0] b);
        master_byte(b, 1'b0, 1'b0, m_ptr, m_ptr, 1'b0);
    endtask

    function automatic logic [7:0] own_addr(input logic rw);
        return {7'(BASE + int'(addr_sel)), rw};
    endfunction

    initial begin
        logic       hit;
        logic [7:0] b;
        int         n;
        int         kind;

        tick(3);
        check("reset outputs",
              32'({o_busy, o_send_ack, o_out_en, o_we, o_clear_start, o_clear_stop, o_shift_en, o_bit_idx, o_reg_ptr}),
              32'd0);
        reset = 1'b0;
        tick(3);

        // Register write with pointer auto-increment.
        addr_sel = 2'd0;
        send_start();
        do_addr(8'h40, hit);
        do_ptr(8'h03);
        do_wdata(8'hA5);
        send_stop();
        check("write: ptr after", 32'(o_reg_ptr), 32'd4);

        // Address mismatch is ignored until the next START.
        send_start();
        do_addr(8'h42, hit);
        idle_byte(8'h55);
        send_stop();
        send_start();
        do_addr(8'h40, hit);
        // STOP and START in the same cycle.
        send_stop_start();
        do_addr(8'h40, hit);
        send_stop();

        // Pointer write, repeated START, two-byte read ending in NACK.
        send_start();
        do_addr(8'h40, hit);
        do_ptr(8'h02);
        send_start();
        do_addr(8'h41, hit);
        do_rbyte(1'b1);
        do_rbyte(1'b0);
        send_stop();
        check("read: ptr after", 32'(o_reg_ptr), 32'd4);

        // Wrap from the last register onto read-only register 0.
        send_start();
        do_addr(8'h40, hit);
        do_ptr(8'h07);
        do_wdata(8'h11);
        do_wdata(8'h22);
        send_stop();
        check("wrap: ptr after", 32'(o_reg_ptr), 32'd1);

        // Out-of-range pointer and address offset.
        send_start();
        do_addr(8'h40, hit);
        do_ptr(8'h1F);
        send_stop();
        check("range: ptr", 32'(o_reg_ptr), 32'd0);
        addr_sel = 2'd3;
        send_start();
        do_addr(8'h46, hit);
        send_stop();
        send_start();
        do_addr(8'h40, hit);
        idle_byte(8'h00);
        send_stop();

        // STOP after four data bits: no write.
        addr_sel = 2'd0;
        send_start();
        do_addr(8'h40, hit);
        do_ptr(8'h05);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, mk(1'b0, 1'b0, 0, m_ptr, 1'b1));
        send_stop();

        // Randomised transactions.
        for (int t = 0; t < 30; t++) begin
            addr_sel = 2'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 4));
            send_start();
            case (kind)
                0: begin
                    do_addr(own_addr(1'b0), hit);
                    do_ptr(8'($urandom));
                    n = int'($urandom_range(0, 3));
                    for (int i = 0; i < n; i++) do_wdata(8'($urandom));
                end
                1: begin
                    do_addr(own_addr(1'b0), hit);
                    do_ptr(8'($urandom));
                    send_start();
                    do_addr(own_addr(1'b1), hit);
                    n = int'($urandom_range(1, 4));
                    for (int i = 0; i < n; i++) do_rbyte(i != n - 1);
                end
                2: begin
                    do_addr(own_addr(1'b1), hit);
                    n = int'($urandom_range(1, 3));
                    for (int i = 0; i < n; i++) do_rbyte(i != n - 1);
                end
                3: begin
                    b = 8'($urandom);
                    do_addr(b, hit);
                    if (!hit)      idle_byte(8'($urandom));
                    else if (b[0]) do_rbyte(1'b0);
                    else           do_ptr(8'($urandom));
                end
                default: begin
                    do_addr(own_addr(1'b0), hit);
                    do_ptr(8'($urandom));
                    n = int'($urandom_range(0, 7));
                    for (int i = 0; i < n; i++) clk_bit(1'($urandom), mk(1'b0, 1'b0, 0, m_ptr, 1'b1));
                end
            endcase
            send_stop();
        end

        // Reset in the middle of a read releases SDA immediately.
        addr_sel = 2'd0;
        send_start();
        do_addr(8'h41, hit);
        tick(1);
        check("read drive before reset", 32'(o_out_en), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("reset mid-read {oe,ack,busy}", 32'({o_out_en, o_send_ack, o_busy}), 32'd0);
        tick(2);
        reset = 1'b0;
        m_ptr = 0;
        tick(2);
        check("ptr after reset", 32'(o_reg_ptr), 32'd0);

        tick(5);
        check("slot queue drained", 32'(exp_slot.size()), 32'd0);
        check("write queue drained", 32'(exp_wr.size()), 32'd0);
        check("stop queue drained", 32'(exp_stop.size()), 32'd0);
        check("start queue drained", 32'(exp_start.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
